// File: rtl/jtag_pkg.sv
// Shared TAP definitions: IEEE 1149.1 state encoding and built-in opcodes.
package jtag_pkg;

  typedef enum logic [3:0] {
    EXIT2_DR         = 4'h0,
    EXIT1_DR         = 4'h1,
    SHIFT_DR         = 4'h2,
    PAUSE_DR         = 4'h3,
    SELECT_IR_SCAN   = 4'h4,
    UPDATE_DR        = 4'h5,
    CAPTURE_DR       = 4'h6,
    SELECT_DR_SCAN   = 4'h7,
    EXIT2_IR         = 4'h8,
    EXIT1_IR         = 4'h9,
    SHIFT_IR         = 4'hA,
    PAUSE_IR         = 4'hB,
    RUN_TEST_IDLE    = 4'hC,
    UPDATE_IR        = 4'hD,
    CAPTURE_IR       = 4'hE,
    TEST_LOGIC_RESET = 4'hF
  } tap_state_e;

  // BYPASS is all-ones at whatever IR width is chosen; truncate on use.
  localparam logic [31:0] OP_BYPASS = 32'hFFFF_FFFF;
  localparam logic [31:0] OP_IDCODE = 32'h0000_0001;
  localparam int unsigned USER_BASE = 2;

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP controller; TMS steers the state on every rising TCK.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       TCK,
  input  logic       TRSTn,
  input  logic       TMS,
  output tap_state_e state
);

  tap_state_e state_q, state_d;

  always_ff @(posedge TCK) begin
    if (!TRSTn) state_q <= TEST_LOGIC_RESET;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      TEST_LOGIC_RESET: state_d = TMS ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    state_d = TMS ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_DR_SCAN:   state_d = TMS ? SELECT_IR_SCAN   : CAPTURE_DR;
      CAPTURE_DR:       state_d = TMS ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         state_d = TMS ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         state_d = TMS ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         state_d = TMS ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         state_d = TMS ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        state_d = TMS ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_IR_SCAN:   state_d = TMS ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       state_d = TMS ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         state_d = TMS ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         state_d = TMS ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         state_d = TMS ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         state_d = TMS ? UPDATE_IR        : SHIFT_IR;
      UPDATE_IR:        state_d = TMS ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      default:          state_d = TEST_LOGIC_RESET;
    endcase
  end

  assign state = state_q;

endmodule

// File: rtl/jtag_tap.sv
// JTAG endpoint: TAP FSM, instruction register, BYPASS/IDCODE DRs,
// user DR steering and the negedge TDO driver.
module jtag_tap
  import jtag_pkg::*;
#(
  parameter int unsigned IR_WIDTH = 4,
  parameter logic [31:0] IDCODE   = 32'h1234_5679,
  parameter int unsigned NUM_USER = 2
) (
  input  logic                TCK,
  input  logic                TRSTn,
  input  logic                TMS,
  input  logic                TDI,
  output logic                TDO,
  output logic                TDO_en,
  output logic [3:0]          state,
  output logic [IR_WIDTH-1:0] ir,
  output logic [NUM_USER-1:0] user_sel,
  output logic                user_capture,
  output logic                user_shift,
  output logic                user_update,
  input  logic [NUM_USER-1:0] user_tdo
);

  tap_state_e tap_state;

  logic [IR_WIDTH-1:0] ir_q, ir_d, ir_sr_q, ir_sr_d;
  logic [NUM_USER-1:0] user_sel_q, user_sel_d;
  logic [31:0]         id_sr_q, id_sr_d;
  logic                bypass_q, bypass_d;
  logic                tdo_q, tdo_d, tdo_en_q, tdo_en_d;
  logic                idcode_sel, user_active, bypass_sel, dr_tdo;

  jtag_tap_fsm u_fsm (
    .TCK   (TCK),
    .TRSTn (TRSTn),
    .TMS   (TMS),
    .state (tap_state)
  );

  function automatic logic [NUM_USER-1:0] decode_user(input logic [IR_WIDTH-1:0] op);
    decode_user = '0;
    if (32'(op) >= USER_BASE && 32'(op) < USER_BASE + NUM_USER)
      decode_user = NUM_USER'(1) << (32'(op) - USER_BASE);
  endfunction

  assign idcode_sel  = (ir_q == IR_WIDTH'(OP_IDCODE));
  assign user_active = |user_sel_q;
  // Undefined opcodes fall back to the 1-bit bypass path, same as all-ones.
  assign bypass_sel  = (ir_q == IR_WIDTH'(OP_BYPASS)) || !(idcode_sel || user_active);

  always_comb begin
    ir_d     = ir_q;
    ir_sr_d  = ir_sr_q;
    id_sr_d  = id_sr_q;
    bypass_d = bypass_q;
    case (tap_state)
      CAPTURE_IR: ir_sr_d = IR_WIDTH'(1);
      SHIFT_IR:   ir_sr_d = {TDI, ir_sr_q[IR_WIDTH-1:1]};
      UPDATE_IR:  ir_d    = ir_sr_q;
      CAPTURE_DR: begin
        bypass_d = 1'b0;
        id_sr_d  = IDCODE;
      end
      SHIFT_DR: begin
        if (idcode_sel)      id_sr_d  = {TDI, id_sr_q[31:1]};
        else if (bypass_sel) bypass_d = TDI;
      end
      default: ;
    endcase
    // Entering or sitting in TEST_LOGIC_RESET selects IDCODE on the same edge.
    if (tap_state == TEST_LOGIC_RESET || (tap_state == SELECT_IR_SCAN && TMS))
      ir_d = IR_WIDTH'(OP_IDCODE);
    user_sel_d = decode_user(ir_d);
  end

  always_ff @(posedge TCK) begin
    if (!TRSTn) begin
      ir_q       <= IR_WIDTH'(OP_IDCODE);
      ir_sr_q    <= '0;
      id_sr_q    <= IDCODE;
      bypass_q   <= 1'b0;
      user_sel_q <= '0;
    end else begin
      ir_q       <= ir_d;
      ir_sr_q    <= ir_sr_d;
      id_sr_q    <= id_sr_d;
      bypass_q   <= bypass_d;
      user_sel_q <= user_sel_d;
    end
  end

  always_comb begin
    dr_tdo = bypass_q;
    if (idcode_sel)       dr_tdo = id_sr_q[0];
    else if (user_active) dr_tdo = |(user_sel_q & user_tdo);
    tdo_d    = tdo_q;
    tdo_en_d = 1'b0;
    if (tap_state == SHIFT_IR) begin
      tdo_d    = ir_sr_q[0];
      tdo_en_d = 1'b1;
    end else if (tap_state == SHIFT_DR) begin
      tdo_d    = dr_tdo;
      tdo_en_d = 1'b1;
    end
  end

  // TDO launches on the falling edge so the probe samples it on the next rise.
  always_ff @(negedge TCK) begin
    if (!TRSTn) begin
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_d;
      tdo_en_q <= tdo_en_d;
    end
  end

  assign TDO          = tdo_q;
  assign TDO_en       = tdo_en_q;
  assign state        = tap_state;
  assign ir           = ir_q;
  assign user_sel     = user_sel_q;
  assign user_capture = user_active && (tap_state == CAPTURE_DR);
  assign user_shift   = user_active && (tap_state == SHIFT_DR);
  assign user_update  = user_active && (tap_state == UPDATE_DR);

endmodule

// File: tb/tb_jtag_tap.sv
// Randomised scan bench for jtag_tap; expected TDO streams come from the
// captured-value-then-TDI rule of each data/instruction register.
module tb_jtag_tap;

  localparam int IRW = 4;
  localparam int NU  = 2;
  localparam logic [31:0] ID = 32'h1234_5679;
  localparam logic [3:0] S_TLR = 4'hF, S_RTI = 4'hC, S_SDR = 4'h2, S_PIR = 4'hB;
  localparam int K_IR = 0, K_ID = 1, K_BYP = 2, K_USR = 3;

  logic TCK, TRSTn, TMS, TDI, TDO, TDO_en, user_capture, user_shift, user_update;
  logic [3:0]     state;
  logic [IRW-1:0] ir;
  logic [NU-1:0]  user_sel, user_tdo;
  int errors = 0, checks = 0;

  logic [63:0] r_tdo;
  int r_en, r_cap, r_sh, r_upd;

  jtag_tap #(.IR_WIDTH(IRW), .IDCODE(ID), .NUM_USER(NU)) dut (
    .TCK(TCK), .TRSTn(TRSTn), .TMS(TMS), .TDI(TDI), .TDO(TDO), .TDO_en(TDO_en),
    .state(state), .ir(ir), .user_sel(user_sel), .user_capture(user_capture),
    .user_shift(user_shift), .user_update(user_update), .user_tdo(user_tdo)
  );

  initial TCK = 1'b0;
  always #5 TCK = ~TCK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic step(input logic tms, input logic tdi);
    TMS = tms;
    TDI = tdi;
    @(posedge TCK);
    @(negedge TCK);
    #1;
  endtask

  // From RUN_TEST_IDLE: one full scan of n bits, optionally pausing after bit pause_at.
  task automatic scan(input bit is_ir, input int n, input int pause_at, input int uk,
                      input logic [63:0] tdi_v, input logic [63:0] usr_v);
    logic [2:0] q[$];  // {tms, shifting edge, sample TDO after}
    int in_i, out_i;
    logic t;
    q.push_back(3'b100);
    if (is_ir) q.push_back(3'b100);
    q.push_back(3'b000);
    q.push_back(3'b001);
    for (int i = 0; i < n; i++) begin
      t = (i == n - 1) || (i == pause_at);
      q.push_back({t, 1'b1, !t});
      if (t && i != n - 1) begin
        q.push_back(3'b000); q.push_back(3'b000); q.push_back(3'b100); q.push_back(3'b001);
      end
    end
    q.push_back(3'b100);
    q.push_back(3'b000);
    in_i = 0; out_i = 0; r_tdo = '0; r_en = 0; r_cap = 0; r_sh = 0; r_upd = 0;
    foreach (q[j]) begin
      user_tdo = NU'($urandom);
      if (uk >= 0)
        user_tdo = (user_tdo & ~(NU'(1) << uk)) | (NU'(usr_v[out_i]) << uk);
      step(q[j][2], q[j][1] ? tdi_v[in_i] : 1'($urandom));
      if (q[j][1]) in_i++;
      if (q[j][0]) begin r_tdo[out_i] = TDO; out_i++; end
      if (TDO_en) r_en++;
      if (user_capture) r_cap++;
      if (user_shift) r_sh++;
      if (user_update) r_upd++;
    end
  endtask

  // Each register emits its captured value LSB-first, then the TDI bits it absorbed.
  function automatic logic [63:0] model(input int kind, input int n,
                                        input logic [63:0] tdi_v, input logic [63:0] usr_v);
    logic [31:0] idv;
    idv = ID;
    model = '0;
    for (int i = 0; i < n; i++)
      case (kind)
        K_IR:    model[i] = (i < IRW) ? (i == 0) : tdi_v[i - IRW];
        K_ID:    model[i] = (i < 32) ? idv[i] : tdi_v[i - 32];
        K_BYP:   model[i] = (i == 0) ? 1'b0 : tdi_v[i - 1];
        default: model[i] = usr_v[i];
      endcase
  endfunction

  function automatic int kind_of(input logic [IRW-1:0] op);
    if (int'(op) == 1) return K_ID;
    if (int'(op) >= 2 && int'(op) < 2 + NU) return K_USR;
    return K_BYP;
  endfunction

  function automatic logic [NU-1:0] sel_of(input logic [IRW-1:0] op);
    if (kind_of(op) == K_USR) return NU'(1) << (int'(op) - 2);
    return '0;
  endfunction

  task automatic test_reset();
    TRSTn = 1'b0;
    step(1, 0); step(1, 0);
    TRSTn = 1'b1;
    checks++; if (state !== S_TLR) begin errors++; $display("FAIL por_state: got %h want %h", state, S_TLR); end
    checks++; if (ir !== 4'h1) begin errors++; $display("FAIL por_ir: got %h want 1", ir); end
    checks++; if (user_sel !== 2'b00 || TDO_en !== 1'b0) begin errors++; $display("FAIL por_outs: sel %b en %b want 00/0", user_sel, TDO_en); end
    step(0, 0); step(1, 0); step(0, 0); step(0, 0);
    checks++; if (state !== S_SDR || TDO_en !== 1'b1) begin errors++; $display("FAIL enter_shift_dr: state %h en %b want 2/1", state, TDO_en); end
    TRSTn = 1'b0;
    step(0, 1);
    TRSTn = 1'b1;
    checks++; if (state !== S_TLR || ir !== 4'h1) begin errors++; $display("FAIL trst_from_shift: state %h ir %h want f/1", state, ir); end
    checks++; if (TDO_en !== 1'b0 || TDO !== 1'b0) begin errors++; $display("FAIL trst_tdo: en %b tdo %b want 0/0", TDO_en, TDO); end
    step(0, 0); step(1, 0); step(1, 0); step(0, 0); step(0, 0); step(1, 0); step(0, 0);
    checks++; if (state !== S_PIR || TDO_en !== 1'b0) begin errors++; $display("FAIL pause_ir: state %h en %b want b/0", state, TDO_en); end
    repeat (5) step(1, 0);
    checks++; if (state !== S_TLR) begin errors++; $display("FAIL tms_reset_pause_ir: got %h want f", state); end
    step(0, 0);
  endtask

  task automatic test_five_ones();
    logic [IRW-1:0] op;
    for (int it = 0; it < 6; it++) begin
      do op = IRW'($urandom); while (op == 4'h1);
      scan(1, IRW, -1, -1, 64'(op), '0);
      checks++; if (ir !== op) begin errors++; $display("FAIL walk_ir_load: got %h want %h", ir, op); end
      repeat ($urandom_range(2, 12)) step(1'($urandom), 1'($urandom));
      repeat (5) step(1, 0);
      checks++; if (state !== S_TLR || ir !== 4'h1 || user_sel !== 2'b00) begin
        errors++; $display("FAIL five_ones: state %h ir %h sel %b want f/1/00", state, ir, user_sel);
      end
      step(0, 0);
    end
  endtask

  task automatic test_idcode();
    logic [63:0] tv;
    int p;
    tv = {$urandom, $urandom};
    scan(0, 32, -1, -1, tv, '0);
    checks++; if (r_tdo !== model(K_ID, 32, tv, '0)) begin errors++; $display("FAIL idcode_stream: got %h want %h", r_tdo, model(K_ID, 32, tv, '0)); end
    checks++; if (r_en !== 32) begin errors++; $display("FAIL idcode_en_count: got %0d want 32", r_en); end
    checks++; if (r_cap + r_sh + r_upd !== 0) begin errors++; $display("FAIL idcode_strobes: got %0d want 0", r_cap + r_sh + r_upd); end
    tv = {$urandom, $urandom};
    p = $urandom_range(1, 30);
    scan(0, 40, p, -1, tv, '0);
    checks++; if (r_tdo !== model(K_ID, 40, tv, '0)) begin errors++; $display("FAIL idcode_pause_stream: got %h want %h", r_tdo, model(K_ID, 40, tv, '0)); end
    checks++; if (r_en !== 40) begin errors++; $display("FAIL idcode_pause_en: got %0d want 40", r_en); end
  endtask

  task automatic test_bypass();
    logic [63:0] tv;
    scan(1, IRW, -1, -1, 64'hF, '0);
    checks++; if (r_tdo !== 64'h1) begin errors++; $display("FAIL ir_capture_out: got %h want 1", r_tdo); end
    checks++; if (ir !== 4'hF || user_sel !== 2'b00) begin errors++; $display("FAIL ir_bypass_load: ir %h sel %b want f/00", ir, user_sel); end
    tv = {55'd0, 1'($urandom), 8'hA5};
    scan(0, 9, -1, -1, tv, '0);
    checks++; if (r_tdo !== model(K_BYP, 9, tv, '0)) begin errors++; $display("FAIL bypass_a5: got %h want %h", r_tdo, model(K_BYP, 9, tv, '0)); end
    checks++; if (r_en !== 9) begin errors++; $display("FAIL bypass_en: got %0d want 9", r_en); end
  endtask

  task automatic test_user();
    logic [63:0] tv, uv;
    int n;
    for (int k = NU - 1; k >= 0; k--) begin
      scan(1, IRW, -1, -1, 64'(2 + k), '0);
      checks++; if (ir !== IRW'(2 + k) || user_sel !== NU'(1) << k) begin
        errors++; $display("FAIL user_sel: ir %h sel %b want %h/%b", ir, user_sel, IRW'(2 + k), NU'(1) << k);
      end
      tv = {$urandom, $urandom}; uv = {$urandom, $urandom};
      n = $urandom_range(8, 24);
      scan(0, n, $urandom_range(0, n - 2), k, tv, uv);
      checks++; if (r_tdo !== model(K_USR, n, tv, uv)) begin errors++; $display("FAIL user_tdo_stream: got %h want %h", r_tdo, model(K_USR, n, tv, uv)); end
      checks++; if (r_cap !== 1 || r_sh !== n || r_upd !== 1) begin
        errors++; $display("FAIL user_strobes: cap %0d sh %0d upd %0d want 1/%0d/1", r_cap, r_sh, r_upd, n);
      end
    end
  endtask

  task automatic test_undefined();
    logic [63:0] tv;
    logic [IRW-1:0] ops [2];
    int n;
    ops[0] = 4'h7; ops[1] = 4'h0;
    foreach (ops[j]) begin
      scan(1, IRW, -1, -1, 64'(ops[j]), '0);
      checks++; if (ir !== ops[j] || user_sel !== 2'b00) begin errors++; $display("FAIL undef_load: ir %h sel %b want %h/00", ir, user_sel, ops[j]); end
      tv = {$urandom, $urandom};
      n = $urandom_range(3, 20);
      scan(0, n, -1, -1, tv, '0);
      checks++; if (r_tdo !== model(K_BYP, n, tv, '0)) begin errors++; $display("FAIL undef_bypass: got %h want %h", r_tdo, model(K_BYP, n, tv, '0)); end
      checks++; if (r_cap + r_sh + r_upd !== 0) begin errors++; $display("FAIL undef_strobes: got %0d want 0", r_cap + r_sh + r_upd); end
    end
  endtask

  task automatic test_reset_mid_scan();
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    step(0, 0); step(0, 1);
    TRSTn = 1'b0;
    step(0, 0);
    TRSTn = 1'b1;
    checks++; if (state !== S_TLR || ir !== 4'h1) begin errors++; $display("FAIL mid_scan_reset: state %h ir %h want f/1", state, ir); end
    checks++; if (user_sel !== 2'b00 || TDO_en !== 1'b0) begin errors++; $display("FAIL mid_scan_outs: sel %b en %b want 00/0", user_sel, TDO_en); end
    step(0, 0);
    checks++; if (state !== S_RTI || ir !== 4'h1) begin errors++; $display("FAIL mid_scan_idle: state %h ir %h want c/1", state, ir); end
  endtask

  task automatic test_random();
    logic [IRW-1:0] op;
    logic [63:0] tv, uv;
    int n, p, kd, uk;
    for (int it = 0; it < 12; it++) begin
      op = IRW'($urandom);
      tv = {$urandom, $urandom};
      scan(1, IRW + 2, -1, -1, tv, '0);
      checks++; if (r_tdo !== model(K_IR, IRW + 2, tv, '0) || ir !== tv[IRW+1:2]) begin
        errors++; $display("FAIL rnd_ir_scan: out %h ir %h want %h/%h", r_tdo, ir, model(K_IR, IRW + 2, tv, '0), tv[IRW+1:2]);
      end
      scan(1, IRW, -1, -1, 64'(op), '0);
      kd = kind_of(op);
      uk = (kd == K_USR) ? int'(op) - 2 : -1;
      checks++; if (ir !== op || user_sel !== sel_of(op)) begin errors++; $display("FAIL rnd_decode: ir %h sel %b want %h/%b", ir, user_sel, op, sel_of(op)); end
      n = $urandom_range(1, 48);
      p = (n > 1 && $urandom_range(0, 1) == 1) ? int'($urandom_range(0, n - 2)) : -1;
      tv = {$urandom, $urandom}; uv = {$urandom, $urandom};
      scan(0, n, p, uk, tv, uv);
      checks++; if (r_tdo !== model(kd, n, tv, uv) || r_en !== n) begin
        errors++; $display("FAIL rnd_dr op=%h n=%0d: got %h en %0d want %h en %0d", op, n, r_tdo, r_en, model(kd, n, tv, uv), n);
      end
      checks++; if (r_upd !== ((kd == K_USR) ? 1 : 0)) begin errors++; $display("FAIL rnd_update: got %0d op %h", r_upd, op); end
    end
  endtask

  initial begin
    TRSTn = 1'b0; TMS = 1'b1; TDI = 1'b0; user_tdo = '0;
    test_reset();
    test_five_ones();
    test_idcode();
    test_bypass();
    test_user();
    test_undefined();
    test_reset_mid_scan();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
